// File: rtl/chacha_stream_pkg.sv
// Shared chunk type encoding, store geometry and the request legality rule
// for chunk_streamer and its register file.
package chacha_stream_pkg;

  typedef enum logic [1:0] {
    KEY     = 2'd0,
    NONCE   = 2'd1,
    COUNTER = 2'd2,
    RSVD    = 2'd3
  } chunk_type_e;

  localparam int KEY_WORDS   = 8;
  localparam int NONCE_WORDS = 3;
  localparam int CTR_WORDS   = 1;

  function automatic logic is_legal(input chunk_type_e t, input logic [4:0] idx);
    case (t)
      KEY:     return idx < 5'(KEY_WORDS);
      NONCE:   return idx < 5'(NONCE_WORDS);
      COUNTER: return idx < 5'(CTR_WORDS);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/chunk_regfile.sv
// 12x32 key/nonce/counter store with host write decode and a read mux.
// Define CHUNK_STREAMER_AUTOINC_EN to bump the counter after each served COUNTER chunk.
module chunk_regfile
  import chacha_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [2:0]  cfg_idx,
  input  logic [31:0] cfg_wdata,
  input  chunk_type_e rd_type,
  input  logic [4:0]  rd_index,
  output logic [31:0] rd_data,
  input  logic        ctr_inc
);

  logic [31:0] key_q   [KEY_WORDS];
  logic [31:0] nonce_q [NONCE_WORDS];
  logic [31:0] ctr_q;
  logic        ctr_wr;

  assign ctr_wr = cfg_we && (cfg_sel == COUNTER) && (cfg_idx == 3'd0);

  // NOTE: the store is architecturally visible after reset (reads return 0),
  // so every word is cleared rather than left as uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      for (int i = 0; i < NONCE_WORDS; i++) nonce_q[i] <= '0;
      ctr_q <= '0;
    end else begin
      if (cfg_we && cfg_sel == KEY) key_q[cfg_idx] <= cfg_wdata;
      if (cfg_we && cfg_sel == NONCE && cfg_idx < 3'(NONCE_WORDS))
        nonce_q[cfg_idx[1:0]] <= cfg_wdata;
`ifdef CHUNK_STREAMER_AUTOINC_EN
      // A host write on the same edge wins over the post-serve increment.
      if (ctr_wr) ctr_q <= cfg_wdata;
      else if (ctr_inc) ctr_q <= ctr_q + 32'd1;
`else
      if (ctr_wr) ctr_q <= cfg_wdata;
`endif
    end
  end

`ifndef CHUNK_STREAMER_AUTOINC_EN
  logic unused_ctr_inc;
  assign unused_ctr_inc = ctr_inc;
`endif

  // NOTE: rd_data gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data = '0;
    case (rd_type)
      KEY:     if (rd_index < 5'(KEY_WORDS))   rd_data = key_q[rd_index[2:0]];
      NONCE:   if (rd_index < 5'(NONCE_WORDS)) rd_data = nonce_q[rd_index[1:0]];
      COUNTER: if (rd_index < 5'(CTR_WORDS))   rd_data = ctr_q;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/chunk_streamer.sv
// Serves one 32-bit key/nonce/counter word per new request after RESP_LAT wait cycles.
// Optional counter autoincrement is enabled by defining CHUNK_STREAMER_AUTOINC_EN.
module chunk_streamer
  import chacha_stream_pkg::*;
#(
  parameter int unsigned RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [2:0]  cfg_idx,
  input  logic [31:0] cfg_wdata,
  input  logic        chunk_request,
  input  logic [1:0]  request_type,
  input  logic [4:0]  chunk_index,
  output logic        chunk_valid,
  output logic [1:0]  chunk_type,
  output logic [31:0] chunk,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE, HOLD} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  chunk_type_e cap_type_q;
  logic [31:0] cap_data_q;
  logic [1:0]  last_type_q;
  logic [4:0]  last_index_q;
  logic        last_none_q;
  logic        req_prev_q;
  logic        err_q;

  logic [31:0] rd_data;
  logic        req_new, capture, legal;

  chunk_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_idx   (cfg_idx),
    .cfg_wdata (cfg_wdata),
    .rd_type   (chunk_type_e'(request_type)),
    .rd_index  (chunk_index),
    .rd_data   (rd_data),
    .ctr_inc   ((state_q == DRIVE) && (cap_type_q == COUNTER))
  );

  // A held request is only re-served once its {type,index} pair changes.
  assign req_new = chunk_request &&
                   (!req_prev_q || last_none_q ||
                    ({request_type, chunk_index} != {last_type_q, last_index_q}));
  assign capture = (state_q == IDLE) && req_new;
  assign legal   = is_legal(chunk_type_e'(request_type), chunk_index);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: if (capture) begin
        if (!legal)             state_d = HOLD;
        else if (RESP_LAT == 0) state_d = DRIVE;
        else begin
          state_d = WAIT;
          wait_d  = 3'(RESP_LAT - 1);
        end
      end
      WAIT: if (wait_q == 3'd0) state_d = DRIVE;
            else                wait_d  = wait_q - 3'd1;
      DRIVE:   state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      cap_type_q   <= KEY;
      cap_data_q   <= '0;
      last_type_q  <= '0;
      last_index_q <= '0;
      last_none_q  <= 1'b1;
      req_prev_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      req_prev_q <= chunk_request;
      if (capture) begin
        cap_type_q   <= chunk_type_e'(request_type);
        cap_data_q   <= rd_data;
        last_type_q  <= request_type;
        last_index_q <= chunk_index;
        last_none_q  <= 1'b0;
        if (!legal) err_q <= 1'b1;
      end
    end
  end

  assign chunk_valid = (state_q == DRIVE);
  assign chunk_type  = chunk_valid ? cap_type_q : 2'd0;
  assign chunk       = chunk_valid ? cap_data_q : 32'd0;
  assign err         = err_q;

endmodule
